// File: rtl/r_divider.sv
// Restoring divider: dividend from an 8x8 RAM, divisor from a constant 8x4 ROM.
// One quotient bit is produced per clock; divide-by-zero is flagged without iterating.
module r_divider #(
  parameter int N_ITER = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] adr_ram,
  input  logic [2:0] adr_rom,
  input  logic       wr_en,
  input  logic [2:0] wr_adr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] quot,
  output logic [3:0] rem
);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ram_q [8];
  logic [7:0]  dvd_q, dvd_d;
  logic [3:0]  dvs_q, dvs_d;
  logic [4:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        err_q, err_d;
  logic [12:0] step;
  logic [3:0]  rom_val;

  function automatic logic [3:0] rom_lookup(input logic [2:0] a);
    case (a)
      3'd0:    rom_lookup = 4'b0000;
      3'd1:    rom_lookup = 4'b1100;
      3'd2:    rom_lookup = 4'b0110;
      3'd3:    rom_lookup = 4'b0111;
      3'd4:    rom_lookup = 4'b1000;
      3'd5:    rom_lookup = 4'b0001;
      3'd6:    rom_lookup = 4'b1101;
      default: rom_lookup = 4'b1111;
    endcase
  endfunction

  // One restoring step on {R, D}; returns {R_next, D_next} with the quotient bit in D's LSB.
  // R[4] can never be set while R < divisor holds, but it is honoured as a guaranteed subtract.
  function automatic logic [12:0] div_step(input logic [4:0] r, input logic [7:0] d,
                                           input logic [3:0] dv);
    logic [4:0] t;
    logic       ge;
    logic [4:0] r_new;
    t     = {r[3:0], d[7]};
    ge    = r[4] | (t >= {1'b0, dv});
    r_new = ge ? (t - {1'b0, dv}) : t;
    div_step = {r_new, d[6:0], ge};
  endfunction

  assign rom_val = rom_lookup(adr_rom);
  assign step    = div_step(r_q, dvd_q, dvs_q);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        dvd_d = ram_q[adr_ram];
        dvs_d = rom_val;
        r_d   = 5'd0;
        cnt_d = 3'd0;
        if (rom_val == 4'd0) begin
          state_d = DONE;
          err_d   = 1'b1;
          quot_d  = 8'hFF;
          rem_d   = 4'h0;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        {r_d, dvd_d} = step;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'(N_ITER - 1)) begin
          state_d = DONE;
          quot_d  = step[7:0];
          rem_d   = step[11:8];
          err_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= 8'h00;
      dvs_q   <= 4'h0;
      r_q     <= 5'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'h00;
      rem_q   <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Write port is independent of the FSM; the LOAD read sees the pre-edge contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) ram_q[i] <= 8'h00;
    end else if (wr_en) begin
      ram_q[wr_adr] <= wr_data;
    end
  end

  assign busy = (state_q == LOAD) || (state_q == DIV);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_r_divider.sv
// Scoreboard bench for r_divider: stimulus queues expected results, a monitor checks each done pulse.
module tb_r_divider;

  logic       clk = 1'b0;
  logic       rst, start, wr_en;
  logic [2:0] adr_ram, adr_rom, wr_adr;
  logic [7:0] wr_data;
  logic       busy, done, err;
  logic [7:0] quot;
  logic [3:0] rem;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int M_NONE     = 0;
  localparam int M_MIDSTART = 1;
  localparam int M_CHANGE   = 2;
  localparam int M_COLLIDE  = 3;

  r_divider #(.N_ITER(8)) dut (
    .clk(clk), .rst(rst), .start(start), .adr_ram(adr_ram), .adr_rom(adr_rom),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no done (quot=%0h rem=%0h)", quot, rem);
      end else begin
        e = sb.pop_front();
        chk("sb_quot", quot, e.q);
        chk("sb_rem",  rem,  e.r);
        chk("sb_err",  err,  e.e);
      end
    end
  end

  task automatic ram_wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_adr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] ra, input logic [2:0] ro, input logic [7:0] eq,
                       input logic [3:0] er, input logic ee, input int mode, input string tag);
    int c, bcnt, elat;
    bit got;
    elat = ee ? 1 : 9;
    sb.push_back('{q: eq, r: er, e: ee});
    @(posedge clk); #1;
    adr_ram = ra; adr_rom = ro; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; bcnt = 0; got = 0;
    while (!got && c < 40) begin
      if (mode == M_COLLIDE && c == 0) begin wr_en = 1'b1; wr_adr = ra; wr_data = 8'hFF; end
      if (mode == M_COLLIDE && c == 1) wr_en = 1'b0;
      if (mode == M_CHANGE && c == 1) begin
        adr_ram = ra + 3'd1; adr_rom = 3'd0;
        wr_en = 1'b1; wr_adr = ra; wr_data = 8'h00;
      end
      if (mode == M_CHANGE && c == 3) wr_en = 1'b0;
      if (mode == M_MIDSTART && c == 3) start = 1'b1;
      if (mode == M_MIDSTART && c == 4) start = 1'b0;
      @(negedge clk);
      if (busy) bcnt++;
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done after %0d edges", tag, elat);
      void'(sb.pop_front());
    end else begin
      chk({tag, "_latency"}, c, elat);
      chk({tag, "_busy_cycles"}, bcnt, elat);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 1'b0);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    adr_ram = 3'd0; adr_rom = 3'd0; wr_adr = 3'd0; wr_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err",  err,  1'b0);
    chk("rst_quot", quot, 8'h00);
    chk("rst_rem",  rem,  4'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    ram_wr(3'd0, 8'h48);
    ram_wr(3'd1, 8'h38);
    ram_wr(3'd2, 8'h0D);
    ram_wr(3'd3, 8'hFF);
    ram_wr(3'd4, 8'h00);
    ram_wr(3'd5, 8'hFF);

    do_op(3'd0, 3'd1, 8'h06, 4'h0, 1'b0, M_NONE,     "basic_72_12");
    do_op(3'd1, 3'd4, 8'h07, 4'h0, 1'b0, M_NONE,     "div_56_8");
    do_op(3'd2, 3'd6, 8'h01, 4'h0, 1'b0, M_NONE,     "div_13_13");
    do_op(3'd3, 3'd3, 8'h24, 4'h3, 1'b0, M_NONE,     "div_255_7");
    do_op(3'd4, 3'd7, 8'h00, 4'h0, 1'b0, M_NONE,     "div_0_15");
    do_op(3'd5, 3'd5, 8'hFF, 4'h0, 1'b0, M_NONE,     "div_255_1");
    do_op(3'd0, 3'd0, 8'hFF, 4'h0, 1'b1, M_NONE,     "div_by_zero");
    do_op(3'd1, 3'd4, 8'h07, 4'h0, 1'b0, M_NONE,     "err_clear");
    do_op(3'd1, 3'd4, 8'h07, 4'h0, 1'b0, M_MIDSTART, "mid_start");
    repeat (4) @(negedge clk);
    do_op(3'd2, 3'd6, 8'h01, 4'h0, 1'b0, M_COLLIDE,  "collide_t1");
    do_op(3'd3, 3'd3, 8'h24, 4'h3, 1'b0, M_CHANGE,   "operand_change");

    // Abort in the 4th DIV cycle; no result may be reported for this operation.
    @(posedge clk); #1;
    adr_ram = 3'd5; adr_rom = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quot", quot, 8'h00);
    chk("abort_rem",  rem,  4'h0);
    chk("abort_err",  err,  1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);

    do_op(3'd0, 3'd1, 8'h00, 4'h0, 1'b0, M_NONE, "ram_cleared");
    ram_wr(3'd0, 8'h48);
    do_op(3'd0, 3'd1, 8'h06, 4'h0, 1'b0, M_NONE, "after_reset");

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
